// File: rtl/vram_pkg.sv
// Shared widths, opcodes and FSM encodings for the text VRAM arbiter.
package vram_pkg;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_CLEAR_ROW = 2'b10,
    OP_SCROLL    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_RDWAIT = 2'b10,
    ST_FILL   = 2'b11
  } state_e;

  function automatic logic [ADDR_W-1:0] vram_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/vram_row_fill.sv
// Column walker for row clears: restarts on start, advances one column per step.
// done is combinational in the step cycle that writes the last column.
module vram_row_fill
  import vram_pkg::*;
#(
  parameter int COLS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  output logic [COL_W-1:0] fill_col,
  output logic             done
);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [COL_W-1:0] fill_col_q, fill_col_d;

  always_comb begin
    fill_col_d = fill_col_q;
    done       = step && (fill_col_q == LAST_COL);
    if (start) begin
      fill_col_d = '0;
    end else if (step) begin
      fill_col_d = done ? '0 : fill_col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_col_q <= '0;
    end else begin
      fill_col_q <= fill_col_d;
    end
  end

  assign fill_col = fill_col_q;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM share: display fetch always wins (1-cycle read), terminal ops
// use idle cycles and stall in PEND/FILL while disp_ce is high; req_ready only in IDLE.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int          ROWS       = 30,
  parameter int          COLS       = 100,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_ce,
  input  logic [ROW_W-1:0]  disp_row,
  input  logic [COL_W-1:0]  disp_col,
  output logic [7:0]        disp_char,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic [7:0]        req_char,
  output logic              rsp_valid,
  output logic [7:0]        rsp_char,
  output logic [ROW_W-1:0]  top_row,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  localparam logic [ROW_W:0]   ROWS_X   = (ROW_W + 1)'(ROWS);
  localparam logic [ROW_W-1:0] ROWS_R   = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       char_q, char_d;
  logic [ROW_W-1:0] phys_row_q, phys_row_d;
  logic [ROW_W-1:0] top_row_q, top_row_d;
  logic             rd_bad_q, rd_bad_d;

  logic             fill_start, fill_step, fill_done;
  logic [COL_W-1:0] fill_col;
  logic             host_issue;
  logic [ROW_W:0]   row_sum;
  logic [ROW_W-1:0] mapped_row;
  op_e              req_op_e;
  logic             row_bad, col_bad;

  vram_row_fill #(.COLS(COLS)) u_fill (
    .clk      (clk),
    .reset    (reset),
    .start    (fill_start),
    .step     (fill_step),
    .fill_col (fill_col),
    .done     (fill_done)
  );

  // Logical-to-physical row: both operands < ROWS, so one conditional subtract wraps.
  always_comb begin
    row_sum    = {1'b0, top_row_q} + {1'b0, req_row};
    mapped_row = (row_sum >= ROWS_X) ? ROW_W'(row_sum - ROWS_X) : row_sum[ROW_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    col_d      = col_q;
    char_d     = char_q;
    phys_row_d = phys_row_q;
    top_row_d  = top_row_q;
    rd_bad_d   = rd_bad_q;
    fill_start = 1'b0;
    fill_step  = 1'b0;
    host_issue = 1'b0;
    rsp_valid  = 1'b0;
    rsp_char   = '0;
    req_ready  = (state_q == ST_IDLE);
    req_op_e   = op_e'(req_op);
    row_bad    = (req_row >= ROWS_R);
    col_bad    = (req_col >= COLS_C);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op_e;
          col_d      = req_col;
          char_d     = req_char;
          phys_row_d = mapped_row;
          rd_bad_d   = 1'b0;
          case (req_op_e)
            OP_WRITE: begin
              if (!(row_bad || col_bad)) state_d = ST_PEND;
            end
            OP_READ: begin
              // Out-of-range reads skip the RAM and answer CLEAR_CHAR next cycle.
              rd_bad_d = row_bad || col_bad;
              state_d  = (row_bad || col_bad) ? ST_RDWAIT : ST_PEND;
            end
            OP_CLEAR_ROW: begin
              if (!row_bad) begin
                state_d    = ST_FILL;
                fill_start = 1'b1;
              end
            end
            OP_SCROLL: begin
              phys_row_d = top_row_q;
              state_d    = ST_FILL;
              fill_start = 1'b1;
            end
          endcase
        end
      end
      ST_PEND: begin
        if (!disp_ce) begin
          host_issue = 1'b1;
          state_d    = (op_q == OP_READ) ? ST_RDWAIT : ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        rsp_valid = 1'b1;
        rsp_char  = rd_bad_q ? CLEAR_CHAR : ram_rdata;
        state_d   = ST_IDLE;
      end
      ST_FILL: begin
        if (!disp_ce) begin
          host_issue = 1'b1;
          fill_step  = 1'b1;
          if (fill_done) begin
            state_d = ST_IDLE;
            if (op_q == OP_SCROLL) begin
              top_row_d = (top_row_q == LAST_ROW) ? '0 : top_row_q + ROW_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = vram_addr(disp_row, disp_col);
    ram_wdata = CLEAR_CHAR;
    if (disp_ce) begin
      ram_ce = 1'b1;
    end else if (host_issue) begin
      ram_ce = 1'b1;
      if (state_q == ST_FILL) begin
        ram_we   = 1'b1;
        ram_addr = vram_addr(phys_row_q, fill_col);
      end else begin
        ram_we    = (op_q == OP_WRITE);
        ram_addr  = vram_addr(phys_row_q, col_q);
        ram_wdata = char_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      col_q      <= '0;
      char_q     <= '0;
      phys_row_q <= '0;
      top_row_q  <= '0;
      rd_bad_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      col_q      <= col_d;
      char_q     <= char_d;
      phys_row_q <= phys_row_d;
      top_row_q  <= top_row_d;
      rd_bad_q   <= rd_bad_d;
    end
  end

  assign disp_char = ram_rdata;
  assign top_row   = top_row_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural registered VRAM.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        disp_ce = 1'b0;
  logic [4:0]  disp_row = '0;
  logic [6:0]  disp_col = '0;
  logic [7:0]  disp_char;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_row = '0;
  logic [6:0]  req_col = '0;
  logic [7:0]  req_char = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_char;
  logic [4:0]  top_row;
  logic        ram_ce, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_ce(disp_ce), .disp_row(disp_row), .disp_col(disp_col), .disp_char(disp_char),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_row(req_row),
    .req_col(req_col), .req_char(req_char), .rsp_valid(rsp_valid), .rsp_char(rsp_char),
    .top_row(top_row), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [7:0]  mem [0:4095];
  int          acc_cnt = 0, wr_cnt = 0, fill_err = 0, rsp_cnt = 0;
  logic [11:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0, rsp_last = '0;
  logic        chk_fill = 1'b0;
  logic [4:0]  exp_fill_row = '0;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
    if (ram_ce && !disp_ce) acc_cnt <= acc_cnt + 1;
    if (ram_ce && ram_we) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= ram_addr;
      last_wdata <= ram_wdata;
      if (chk_fill && (ram_addr[11:7] != exp_fill_row || ram_addr[6:0] >= 7'd100 ||
                       ram_wdata != 8'h20))
        fill_err <= fill_err + 1;
    end
    if (rsp_valid) begin
      rsp_cnt  <= rsp_cnt + 1;
      rsp_last <= rsp_char;
    end
  end

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int disp_mode = 0;  // 0 off, 1 one fetch per 10 cycles, 3 driven by hand

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next negedge; verify the display read of the cycle just ended.
  task automatic step();
    logic        was;
    logic [11:0] a;
    was = disp_ce;
    a   = {disp_row, disp_col};
    @(negedge clk);
    cyc++;
    if (was) chk("disp_char", {24'b0, disp_char}, {24'b0, mem[a]});
    case (disp_mode)
      0: disp_ce = 1'b0;
      1: begin
        disp_ce  = (cyc % 10 == 0);
        disp_row = 5'(cyc % 30);
        disp_col = 7'(cyc % 100);
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input int row, input int col, input logic [7:0] ch);
    int n;
    n = 0;
    req_op = op; req_row = 5'(row); req_col = 7'(col); req_char = ch; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 400) begin
      step(); #1; n++;
    end
    chk("send_ready", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (!req_ready && n < 400) begin
      step(); #1; n++;
    end
    chk("idle_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic ce; logic [4:0] row; logic [6:0] col;
    logic exp_ce; logic exp_we; logic [11:0] exp_addr;
  } mux_vec_t;

  typedef struct {
    logic [1:0] op; int row; int col; logic [7:0] ch;
    int exp_acc; int exp_wr; logic [11:0] exp_addr; int exp_rsp; logic [7:0] exp_rsp_char;
  } op_vec_t;

  initial begin
    mux_vec_t mv [6];
    op_vec_t  ov [10];
    int a0, w0, r0, f0, bad;

    mv[0] = '{1'b1, 5'd0,  7'd0,   1'b1, 1'b0, 12'h000};
    mv[1] = '{1'b1, 5'd3,  7'd5,   1'b1, 1'b0, 12'h185};
    mv[2] = '{1'b1, 5'd29, 7'd99,  1'b1, 1'b0, 12'hEE3};
    mv[3] = '{1'b0, 5'd3,  7'd5,   1'b0, 1'b0, 12'h000};
    mv[4] = '{1'b1, 5'd31, 7'd127, 1'b1, 1'b0, 12'hFFF};
    mv[5] = '{1'b1, 5'd1,  7'd0,   1'b1, 1'b0, 12'h080};

    ov[0] = '{OP_WRITE, 0,  0,   8'h5A, 1, 1, 12'h000, 0, 8'h00};
    ov[1] = '{OP_WRITE, 29, 99,  8'h71, 1, 1, 12'hEE3, 0, 8'h00};
    ov[2] = '{OP_READ,  29, 99,  8'h00, 1, 0, 12'h000, 1, 8'h71};
    ov[3] = '{OP_READ,  4,  6,   8'h00, 1, 0, 12'h000, 1, 8'h42};
    ov[4] = '{OP_READ,  3,  120, 8'h00, 0, 0, 12'h000, 1, 8'h20};
    ov[5] = '{OP_WRITE, 30, 5,   8'h78, 0, 0, 12'h000, 0, 8'h00};
    ov[6] = '{OP_READ,  31, 0,   8'h00, 0, 0, 12'h000, 1, 8'h20};
    ov[7] = '{OP_READ,  0,  0,   8'h00, 1, 0, 12'h000, 1, 8'h5A};
    ov[8] = '{OP_WRITE, 3,  100, 8'h55, 0, 0, 12'h000, 0, 8'h00};
    ov[9] = '{OP_WRITE, 29, 0,   8'h21, 1, 1, 12'hE80, 0, 8'h00};

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_top_row", {27'b0, top_row}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_char", {24'b0, rsp_char}, 32'd0);
    chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);

    // Display mux in IDLE
    disp_mode = 3;
    for (int i = 0; i < 6; i++) begin
      disp_ce = mv[i].ce; disp_row = mv[i].row; disp_col = mv[i].col;
      #1;
      chk($sformatf("mux%0d_ce", i), {31'b0, ram_ce}, {31'b0, mv[i].exp_ce});
      chk($sformatf("mux%0d_we", i), {31'b0, ram_we}, {31'b0, mv[i].exp_we});
      if (mv[i].exp_ce) chk($sformatf("mux%0d_addr", i), {20'b0, ram_addr}, {20'b0, mv[i].exp_addr});
      step();
    end
    disp_ce = 1'b0;

    // Single WRITE with idle display
    req_op = OP_WRITE; req_row = 5'd3; req_col = 7'd5; req_char = 8'h41; req_valid = 1'b1;
    #1;
    chk("t1_ready", {31'b0, req_ready}, 32'd1);
    chk("t1_no_ram_idle", {31'b0, ram_ce}, 32'd0);
    step(); req_valid = 1'b0; #1;
    chk("t1_ram_ce", {31'b0, ram_ce}, 32'd1);
    chk("t1_ram_we", {31'b0, ram_we}, 32'd1);
    chk("t1_addr", {20'b0, ram_addr}, 32'h185);
    chk("t1_wdata", {24'b0, ram_wdata}, 32'h41);
    chk("t1_busy", {31'b0, req_ready}, 32'd0);
    step(); #1;
    chk("t1_ready_back", {31'b0, req_ready}, 32'd1);
    chk("t1_ram_quiet", {31'b0, ram_ce}, 32'd0);

    // Pending WRITE blocked for 4 display cycles
    req_op = OP_WRITE; req_row = 5'd4; req_col = 7'd6; req_char = 8'h42; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    disp_ce = 1'b1; disp_row = 5'd3; disp_col = 7'd5;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_no_host_we", {31'b0, ram_we}, 32'd0);
      chk("t2_disp_addr", {20'b0, ram_addr}, 32'h185);
      step();
    end
    disp_ce = 1'b0; #1;
    chk("t2_issue_we", {31'b0, ram_we}, 32'd1);
    chk("t2_issue_addr", {20'b0, ram_addr}, 32'h206);
    chk("t2_issue_wdata", {24'b0, ram_wdata}, 32'h42);
    step(); #1;
    chk("t2_ready", {31'b0, req_ready}, 32'd1);

    // READ blocked 2 cycles: response 2 cycles after last blocked cycle
    req_op = OP_READ; req_row = 5'd3; req_col = 7'd5; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    disp_ce = 1'b1; disp_row = 5'd4; disp_col = 7'd6;
    repeat (2) begin
      #1; chk("t3_no_rsp", {31'b0, rsp_valid}, 32'd0);
      step();
    end
    disp_ce = 1'b0; #1;
    chk("t3_rd_ce", {31'b0, ram_ce}, 32'd1);
    chk("t3_rd_we", {31'b0, ram_we}, 32'd0);
    chk("t3_rd_addr", {20'b0, ram_addr}, 32'h185);
    step(); #1;
    chk("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t3_rsp_char", {24'b0, rsp_char}, 32'h41);
    step(); #1;
    chk("t3_rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("t3_ready", {31'b0, req_ready}, 32'd1);
    disp_mode = 0;

    // Table of single operations, top_row = 0
    for (int i = 0; i < 10; i++) begin
      a0 = acc_cnt; w0 = wr_cnt; r0 = rsp_cnt;
      send(ov[i].op, ov[i].row, ov[i].col, ov[i].ch);
      repeat (4) step();
      #1;
      chk($sformatf("tbl%0d_acc", i), acc_cnt - a0, ov[i].exp_acc);
      chk($sformatf("tbl%0d_wr", i), wr_cnt - w0, ov[i].exp_wr);
      if (ov[i].exp_wr != 0) begin
        chk($sformatf("tbl%0d_waddr", i), {20'b0, last_waddr}, {20'b0, ov[i].exp_addr});
        chk($sformatf("tbl%0d_wdata", i), {24'b0, last_wdata}, {24'b0, ov[i].ch});
      end
      chk($sformatf("tbl%0d_rsp", i), rsp_cnt - r0, ov[i].exp_rsp);
      if (ov[i].exp_rsp != 0)
        chk($sformatf("tbl%0d_rsp_char", i), {24'b0, rsp_last}, {24'b0, ov[i].exp_rsp_char});
    end

    // CLEAR_ROW 29 with background display traffic
    disp_mode = 1;
    chk_fill = 1'b1; exp_fill_row = 5'd29;
    w0 = wr_cnt; f0 = fill_err;
    send(OP_CLEAR_ROW, 29, 0, 8'h00);
    wait_idle();
    chk("t4_writes", wr_cnt - w0, 32'd100);
    chk("t4_fill_err", fill_err - f0, 32'd0);
    bad = 0;
    for (int c = 0; c < 100; c++) if (mem[{5'd29, 7'(c)}] != 8'h20) bad++;
    chk("t4_row_content", bad, 32'd0);
    chk("t4_top_row", {27'b0, top_row}, 32'd0);

    // 30 SCROLLs: top_row walks to 29 then wraps to 0
    f0 = fill_err;
    for (int i = 0; i < 30; i++) begin
      exp_fill_row = 5'(i); w0 = wr_cnt;
      send(OP_SCROLL, 0, 0, 8'h00);
      chk($sformatf("t5_hold%0d", i), {27'b0, top_row}, i);
      wait_idle();
      chk($sformatf("t5_top%0d", i), {27'b0, top_row}, (i == 29) ? 0 : i + 1);
      chk($sformatf("t5_wr%0d", i), wr_cnt - w0, 32'd100);
    end
    chk("t5_fill_err", fill_err - f0, 32'd0);

    // Walk top_row to 28 without display traffic
    disp_mode = 0;
    for (int i = 0; i < 28; i++) begin
      exp_fill_row = 5'(i);
      send(OP_SCROLL, 0, 0, 8'h00);
      wait_idle();
    end
    chk("t6_fill_err", fill_err - f0, 32'd0);
    chk("t6_top28", {27'b0, top_row}, 32'd28);
    chk_fill = 1'b0;

    // Logical-to-physical mapping with top_row = 28
    send(OP_WRITE, 5, 10, 8'h4D); repeat (2) step(); #1;
    chk("t6_map_r5", {20'b0, last_waddr}, 32'h18A);
    r0 = rsp_cnt;
    send(OP_READ, 5, 10, 8'h00); repeat (3) step(); #1;
    chk("t6_read_r5_cnt", rsp_cnt - r0, 32'd1);
    chk("t6_read_r5", {24'b0, rsp_last}, 32'h4D);
    send(OP_WRITE, 2, 0, 8'h57); repeat (2) step(); #1;
    chk("t6_map_wrap", {20'b0, last_waddr}, 32'h000);
    send(OP_WRITE, 1, 1, 8'h56); repeat (2) step(); #1;
    chk("t6_map_r1", {20'b0, last_waddr}, 32'hE81);

    // Out-of-range READ answers next cycle without touching the RAM
    a0 = acc_cnt;
    req_op = OP_READ; req_row = 5'd0; req_col = 7'd120; req_valid = 1'b1;
    step(); req_valid = 1'b0; #1;
    chk("t6_oor_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t6_oor_rsp_char", {24'b0, rsp_char}, 32'h20);
    chk("t6_oor_ram_ce", {31'b0, ram_ce}, 32'd0);
    step(); #1;
    chk("t6_oor_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("t6_oor_acc", acc_cnt - a0, 32'd0);

    // CLEAR_ROW with a bad row is a no-op
    w0 = wr_cnt;
    send(OP_CLEAR_ROW, 30, 0, 8'h00); #1;
    chk("t6_bad_clr_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) step(); #1;
    chk("t6_bad_clr_wr", wr_cnt - w0, 32'd0);

    // Reset in the middle of a SCROLL fill
    send(OP_SCROLL, 0, 0, 8'h00);
    repeat (20) step(); #1;
    chk("t7_top_midfill", {27'b0, top_row}, 32'd28);
    chk("t7_filling", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("t7_ready", {31'b0, req_ready}, 32'd1);
    chk("t7_top_row", {27'b0, top_row}, 32'd0);
    chk("t7_ram_ce", {31'b0, ram_ce}, 32'd0);
    w0 = wr_cnt;
    repeat (5) step(); #1;
    chk("t7_no_writes", wr_cnt - w0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
